// File: rtl/text_console.sv
// Character console: turns a stream of character codes into name-table writes,
// tracking a cursor and blanking a row on every line advance or the whole screen.
module text_console #(
   parameter int unsigned COLS       = 80,
   parameter int unsigned ROWS       = 60,
   parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
   input  logic        clk100mhz,
   input  logic        resetN,
   input  logic        charValid,
   input  logic [7:0]  charData,
   output logic        charReady,
   output logic        nameTableWriteEnable,
   output logic [7:0]  nameTableWriteData,
   output logic [12:0] nameTableWriteAddr,
   output logic [6:0]  cursorX,
   output logic [5:0]  cursorY
);

   localparam int unsigned AW = 13;
   localparam int unsigned XW = 7;
   localparam int unsigned YW = 6;
   localparam int unsigned DW = 8;

   localparam logic [AW-1:0] LAST_CELL    = AW'(COLS * ROWS - 1);
   localparam logic [AW-1:0] LAST_COL_CNT = AW'(COLS - 1);
   localparam logic [XW-1:0] LAST_COL     = XW'(COLS - 1);
   localparam logic [YW-1:0] LAST_ROW     = YW'(ROWS - 1);

   typedef enum logic [1:0] {
      CLEAR_ALL  = 2'd0,
      IDLE       = 2'd1,
      LINE_CLEAR = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          ready_q, ready_d;
   logic          we_q, we_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [AW-1:0] waddr_q, waddr_d;

   logic          accept_c;
   logic          printable_c;
   logic [AW-1:0] row_base_c;
   logic [YW-1:0] next_row_c;
   logic [DW-1:0] tab_c;

   // ready is only ever high in IDLE, so an accept implies IDLE
   assign accept_c    = charValid & ready_q;
   assign printable_c = (charData >= 8'h20) && (charData <= 8'h7E);
   assign row_base_c  = AW'(y_q) * AW'(COLS);
   assign next_row_c  = (y_q == LAST_ROW) ? '0 : y_q + YW'(1);
   assign tab_c       = ({1'b0, x_q} | DW'(7)) + DW'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      we_d    = 1'b0;
      wdata_d = wdata_q;
      waddr_d = waddr_q;

      case (state_q)
         CLEAR_ALL: begin
            we_d    = 1'b1;
            wdata_d = BLANK_CHAR;
            waddr_d = cnt_q;
            if (cnt_q == LAST_CELL) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end

         LINE_CLEAR: begin
            // cursorY already points at the freshly entered row
            we_d    = 1'b1;
            wdata_d = BLANK_CHAR;
            waddr_d = row_base_c + cnt_q;
            if (cnt_q == LAST_COL_CNT) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end

         IDLE: begin
            if (accept_c) begin
               if (printable_c) begin
                  we_d    = 1'b1;
                  wdata_d = charData;
                  waddr_d = row_base_c + AW'(x_q);
                  if (x_q == LAST_COL) begin
                     x_d     = '0;
                     y_d     = next_row_c;
                     state_d = LINE_CLEAR;
                     cnt_d   = '0;
                  end else begin
                     x_d = x_q + XW'(1);
                  end
               end else begin
                  case (charData)
                     8'h0A: begin
                        x_d     = '0;
                        y_d     = next_row_c;
                        state_d = LINE_CLEAR;
                        cnt_d   = '0;
                     end
                     8'h0D: x_d = '0;
                     8'h08: begin
                        if (x_q != '0) begin
                           x_d     = x_q - XW'(1);
                           we_d    = 1'b1;
                           wdata_d = BLANK_CHAR;
                           waddr_d = row_base_c + AW'(x_q) - AW'(1);
                        end
                     end
                     8'h09: x_d = (tab_c > DW'(LAST_COL)) ? LAST_COL : XW'(tab_c);
                     8'h0C: begin
                        x_d     = '0;
                        y_d     = '0;
                        state_d = CLEAR_ALL;
                        cnt_d   = '0;
                     end
                     default: ;
                  endcase
               end
            end
         end

         default: begin
            state_d = CLEAR_ALL;
            cnt_d   = '0;
         end
      endcase

      // first IDLE cycle after a sweep still reports busy
      ready_d = (state_q == IDLE) && (state_d == IDLE);
   end

   always_ff @(posedge clk100mhz) begin
      if (!resetN) begin
         state_q <= CLEAR_ALL;
         cnt_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         waddr_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         ready_q <= ready_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         waddr_q <= waddr_d;
      end
   end

   assign charReady            = ready_q;
   assign nameTableWriteEnable = we_q;
   assign nameTableWriteData   = wdata_q;
   assign nameTableWriteAddr   = waddr_q;
   assign cursorX              = x_q;
   assign cursorY              = y_q;

endmodule

// File: tb/tb_text_console.sv
// Bench for text_console: random and directed character streams compared
// against a cursor/write-list model of the console behaviour.
module tb_text_console;

   localparam int COLS  = 80;
   localparam int ROWS  = 60;
   localparam int CELLS = COLS * ROWS;
   localparam int BLANK = 8'h20;
   localparam int LIMIT = 6000;

   logic        clk100mhz = 1'b0;
   logic        resetN    = 1'b0;
   logic        charValid = 1'b0;
   logic [7:0]  charData  = 8'h00;
   logic        charReady;
   logic        nameTableWriteEnable;
   logic [7:0]  nameTableWriteData;
   logic [12:0] nameTableWriteAddr;
   logic [6:0]  cursorX;
   logic [5:0]  cursorY;

   int n_vec = 0;
   int n_err = 0;
   int mx = 0;
   int my = 0;
   int exp_q[$];
   int obs_q[$];

   text_console #(.COLS(COLS), .ROWS(ROWS), .BLANK_CHAR(8'h20)) dut (
      .clk100mhz            (clk100mhz),
      .resetN               (resetN),
      .charValid            (charValid),
      .charData             (charData),
      .charReady            (charReady),
      .nameTableWriteEnable (nameTableWriteEnable),
      .nameTableWriteData   (nameTableWriteData),
      .nameTableWriteAddr   (nameTableWriteAddr),
      .cursorX              (cursorX),
      .cursorY              (cursorY)
   );

   always #5 clk100mhz = ~clk100mhz;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model: cursor + list of expected writes
   task automatic model_blank_row();
      for (int i = 0; i < COLS; i++) exp_q.push_back((my * COLS + i) * 256 + BLANK);
   endtask

   task automatic model_clear_all();
      mx = 0;
      my = 0;
      for (int i = 0; i < CELLS; i++) exp_q.push_back(i * 256 + BLANK);
   endtask

   task automatic model_char(input logic [7:0] c);
      if (c >= 8'h20 && c <= 8'h7E) begin
         exp_q.push_back((my * COLS + mx) * 256 + int'(c));
         if (mx == COLS - 1) begin
            mx = 0;
            my = (my + 1) % ROWS;
            model_blank_row();
         end else begin
            mx = mx + 1;
         end
      end else if (c == 8'h0A) begin
         mx = 0;
         my = (my + 1) % ROWS;
         model_blank_row();
      end else if (c == 8'h0D) begin
         mx = 0;
      end else if (c == 8'h08) begin
         if (mx > 0) begin
            mx = mx - 1;
            exp_q.push_back((my * COLS + mx) * 256 + BLANK);
         end
      end else if (c == 8'h09) begin
         mx = (((mx | 7) + 1) < COLS - 1) ? ((mx | 7) + 1) : COLS - 1;
      end else if (c == 8'h0C) begin
         model_clear_all();
      end
   endtask

   // ---------------- stimulus / observation plumbing
   task automatic send(input logic [7:0] c);
      int n = 0;
      while (charReady !== 1'b1 && n < LIMIT) begin
         @(negedge clk100mhz);
         n++;
      end
      n_vec++;
      if (charReady !== 1'b1) begin
         n_err++;
         $display("FAIL send_wait: charReady=%b after %0d cycles, expected 1", charReady, LIMIT);
      end
      charValid = 1'b1;
      charData  = c;
      @(posedge clk100mhz);
      #1 charValid = 1'b0;
   endtask

   // records every write until charReady is seen high again
   task automatic collect(output int holes, output int first_cyc);
      int  last = -1;
      int  nwr  = 0;
      bit  done = 1'b0;
      obs_q.delete();
      first_cyc = -1;
      holes     = 0;
      for (int cyc = 0; cyc <= LIMIT && !done; cyc++) begin
         @(negedge clk100mhz);
         if (nameTableWriteEnable === 1'b1) begin
            obs_q.push_back(int'(nameTableWriteAddr) * 256 + int'(nameTableWriteData));
            if (first_cyc < 0) first_cyc = cyc;
            last = cyc;
            nwr++;
         end
         if (charReady === 1'b1) done = 1'b1;
      end
      if (first_cyc >= 0) holes = last - first_cyc + 1 - nwr;
      n_vec++;
      if (!done) begin
         n_err++;
         $display("FAIL collect_timeout: charReady=%b after %0d cycles, expected 1", charReady, LIMIT);
      end
   endtask

   function automatic int first_diff();
      int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (obs_q[i] != exp_q[i]) return i;
      if (obs_q.size() != exp_q.size()) return n;
      return -1;
   endfunction

   function automatic string wr_str(input int q[$], input int i);
      if (i < 0 || i >= q.size()) return "none";
      return $sformatf("addr %0d data %02h", q[i] >> 8, q[i] & 255);
   endfunction

   // ---------------- scenarios
   task automatic test_reset();
      int holes, fc, d;
      resetN    = 1'b0;
      charValid = 1'b0;
      repeat (3) @(posedge clk100mhz);
      @(negedge clk100mhz);
      n_vec++;
      if ({nameTableWriteEnable, nameTableWriteData, nameTableWriteAddr, cursorX, cursorY, charReady} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: we=%b data=%h addr=%0d x=%0d y=%0d rdy=%b, expected all 0",
                  nameTableWriteEnable, nameTableWriteData, nameTableWriteAddr, cursorX, cursorY, charReady);
      end
      resetN = 1'b1;
      exp_q.delete();
      model_clear_all();
      collect(holes, fc);
      d = first_diff();
      n_vec++;
      if (d != -1) begin
         n_err++;
         $display("FAIL reset_sweep writes[%0d]: got %s expected %s (count %0d vs %0d)",
                  d, wr_str(obs_q, d), wr_str(exp_q, d), obs_q.size(), exp_q.size());
      end
      n_vec++;
      if (holes !== 0 || fc !== 0) begin
         n_err++;
         $display("FAIL reset_sweep_timing: holes=%0d first=%0d, expected 0 and 0", holes, fc);
      end
      n_vec++;
      if ({cursorY, cursorX} !== {6'(my), 7'(mx)}) begin
         n_err++;
         $display("FAIL reset_cursor: got (%0d,%0d) expected (%0d,%0d)", cursorX, cursorY, mx, my);
      end
   endtask

   task automatic test_printable();
      int holes, fc, d;
      exp_q.delete();
      model_char(8'h41);
      send(8'h41);
      collect(holes, fc);
      d = first_diff();
      n_vec++;
      if (d != -1 || fc !== 0) begin
         n_err++;
         $display("FAIL printable writes[%0d]: got %s first=%0d expected %s first=0",
                  d, wr_str(obs_q, d), fc, wr_str(exp_q, d));
      end
      n_vec++;
      if ({cursorY, cursorX, charReady} !== {6'(my), 7'(mx), 1'b1}) begin
         n_err++;
         $display("FAIL printable_cursor: got (%0d,%0d) rdy=%b expected (%0d,%0d) rdy=1",
                  cursorX, cursorY, charReady, mx, my);
      end
   endtask

   // tabs walk the cursor to the last column, then a printable wraps it
   task automatic test_tab_wrap();
      int holes, fc, d;
      logic [7:0] seq [12];
      for (int i = 0; i < 11; i++) seq[i] = 8'h09;
      seq[11] = 8'h42;
      for (int i = 0; i < 12; i++) begin
         exp_q.delete();
         model_char(seq[i]);
         send(seq[i]);
         collect(holes, fc);
         d = first_diff();
         n_vec++;
         if (d != -1 || holes !== 0 || (obs_q.size() > 0 && fc !== 0)) begin
            n_err++;
            $display("FAIL tab_wrap[%0d] writes[%0d]: got %s holes=%0d first=%0d expected %s holes=0 first=0",
                     i, d, wr_str(obs_q, d), holes, fc, wr_str(exp_q, d));
         end
         n_vec++;
         if ({cursorY, cursorX} !== {6'(my), 7'(mx)}) begin
            n_err++;
            $display("FAIL tab_wrap_cursor[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, cursorX, cursorY, mx, my);
         end
      end
   endtask

   task automatic test_backspace();
      int holes, fc, d;
      logic [7:0] seq [7];
      seq = '{8'h0A, 8'h61, 8'h62, 8'h63, 8'h08, 8'h0D, 8'h08};
      for (int i = 0; i < 7; i++) begin
         exp_q.delete();
         model_char(seq[i]);
         send(seq[i]);
         collect(holes, fc);
         d = first_diff();
         n_vec++;
         if (d != -1) begin
            n_err++;
            $display("FAIL backspace[%0d] writes[%0d]: got %s expected %s (count %0d vs %0d)",
                     i, d, wr_str(obs_q, d), wr_str(exp_q, d), obs_q.size(), exp_q.size());
         end
         n_vec++;
         if ({cursorY, cursorX} !== {6'(my), 7'(mx)}) begin
            n_err++;
            $display("FAIL backspace_cursor[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, cursorX, cursorY, mx, my);
         end
      end
   endtask

   // walk to the bottom row and let a newline wrap back to row 0
   task automatic test_newline_wrap();
      int holes, fc, d;
      logic [7:0] c;
      for (int i = 0; i < 63; i++) begin
         c = (i < 57) ? 8'h0A : (i < 62) ? 8'h78 : 8'h0A;
         exp_q.delete();
         model_char(c);
         send(c);
         collect(holes, fc);
         d = first_diff();
         n_vec++;
         if (d != -1 || holes !== 0) begin
            n_err++;
            $display("FAIL newline[%0d] writes[%0d]: got %s holes=%0d expected %s holes=0",
                     i, d, wr_str(obs_q, d), holes, wr_str(exp_q, d));
         end
         n_vec++;
         if ({cursorY, cursorX} !== {6'(my), 7'(mx)}) begin
            n_err++;
            $display("FAIL newline_cursor[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, cursorX, cursorY, mx, my);
         end
      end
   endtask

   // form-feed held valid during a line clear must wait for ready
   task automatic test_held_formfeed();
      int holes, fc, d;
      exp_q.delete();
      model_char(8'h0A);
      while (charReady !== 1'b1) @(negedge clk100mhz);
      charValid = 1'b1;
      charData  = 8'h0A;
      @(posedge clk100mhz);
      #1 charData = 8'h0C;
      collect(holes, fc);
      d = first_diff();
      n_vec++;
      if (d != -1) begin
         n_err++;
         $display("FAIL held_line writes[%0d]: got %s expected %s (count %0d vs %0d)",
                  d, wr_str(obs_q, d), wr_str(exp_q, d), obs_q.size(), exp_q.size());
      end
      n_vec++;
      if ({cursorY, cursorX} !== {6'(my), 7'(mx)}) begin
         n_err++;
         $display("FAIL held_line_cursor: got (%0d,%0d) expected (%0d,%0d)", cursorX, cursorY, mx, my);
      end
      exp_q.delete();
      model_char(8'h0C);
      @(posedge clk100mhz);
      #1 charValid = 1'b0;
      collect(holes, fc);
      d = first_diff();
      n_vec++;
      if (d != -1 || holes !== 0 || fc !== 1) begin
         n_err++;
         $display("FAIL held_clear writes[%0d]: got %s holes=%0d first=%0d expected %s holes=0 first=1",
                  d, wr_str(obs_q, d), holes, fc, wr_str(exp_q, d));
      end
      n_vec++;
      if ({cursorY, cursorX} !== {6'(my), 7'(mx)}) begin
         n_err++;
         $display("FAIL held_clear_cursor: got (%0d,%0d) expected (%0d,%0d)", cursorX, cursorY, mx, my);
      end
   endtask

   task automatic test_reset_mid_sweep();
      int holes, fc, d;
      send(8'h71);
      collect(holes, fc);
      send(8'h0A);
      repeat (20) @(negedge clk100mhz);
      resetN = 1'b0;
      @(negedge clk100mhz);
      n_vec++;
      if ({nameTableWriteEnable, nameTableWriteData, nameTableWriteAddr, cursorX, cursorY, charReady} !== '0) begin
         n_err++;
         $display("FAIL midreset_outputs: we=%b data=%h addr=%0d x=%0d y=%0d rdy=%b, expected all 0",
                  nameTableWriteEnable, nameTableWriteData, nameTableWriteAddr, cursorX, cursorY, charReady);
      end
      resetN = 1'b1;
      exp_q.delete();
      model_clear_all();
      collect(holes, fc);
      d = first_diff();
      n_vec++;
      if (d != -1 || holes !== 0) begin
         n_err++;
         $display("FAIL midreset_sweep writes[%0d]: got %s holes=%0d expected %s holes=0",
                  d, wr_str(obs_q, d), holes, wr_str(exp_q, d));
      end
      n_vec++;
      if ({cursorY, cursorX} !== {6'(my), 7'(mx)}) begin
         n_err++;
         $display("FAIL midreset_cursor: got (%0d,%0d) expected (%0d,%0d)", cursorX, cursorY, mx, my);
      end
   endtask

   task automatic test_random();
      int holes, fc, d, r;
      logic [7:0] c;
      for (int i = 0; i < 250; i++) begin
         r = $urandom_range(0, 99);
         if (r < 55)      c = 8'($urandom_range(32, 126));
         else if (r < 63) c = 8'h0A;
         else if (r < 70) c = 8'h0D;
         else if (r < 80) c = 8'h08;
         else if (r < 88) c = 8'h09;
         else if (r < 89) c = 8'h0C;
         else if (r < 93) c = 8'($urandom_range(0, 7));
         else if (r < 96) c = 8'h7F;
         else             c = 8'($urandom_range(128, 255));
         exp_q.delete();
         model_char(c);
         send(c);
         collect(holes, fc);
         d = first_diff();
         n_vec++;
         if (d != -1 || holes !== 0) begin
            n_err++;
            $display("FAIL random[%0d] code %02h writes[%0d]: got %s holes=%0d expected %s holes=0",
                     i, c, d, wr_str(obs_q, d), holes, wr_str(exp_q, d));
         end
         n_vec++;
         if ({cursorY, cursorX} !== {6'(my), 7'(mx)}) begin
            n_err++;
            $display("FAIL random_cursor[%0d] code %02h: got (%0d,%0d) expected (%0d,%0d)",
                     i, c, cursorX, cursorY, mx, my);
         end
      end
   endtask

   initial begin
      test_reset();
      test_printable();
      test_tab_wrap();
      test_backspace();
      test_newline_wrap();
      test_held_formfeed();
      test_reset_mid_sweep();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
